// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle for pc_gen.
//   master (pc_gen side): drives pc_valid/pc_o, halted, misalign_o/misalign_pc, issue_cnt;
//                         samples fetch_ready, redirect_*, trap_*, halt_req, resume_req.
//   slave (core/fetch side): the mirror image.
interface pc_gen_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             fetch_ready;
  logic             pc_valid;
  logic [XLEN-1:0]  pc_o;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_pc;
  logic             halt_req;
  logic             resume_req;
  logic             halted;
  logic             misalign_o;
  logic [XLEN-1:0]  misalign_pc;
  logic [CNT_W-1:0] issue_cnt;
  modport master (
    input  fetch_ready, redirect_valid, redirect_pc, trap_valid, trap_pc, halt_req, resume_req,
    output pc_valid, pc_o, halted, misalign_o, misalign_pc, issue_cnt
  );
  modport slave (
    output fetch_ready, redirect_valid, redirect_pc, trap_valid, trap_pc, halt_req, resume_req,
    input  pc_valid, pc_o, halted, misalign_o, misalign_pc, issue_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: RV32 fetch program-counter generator with trap/redirect/halt and misalign fault.
//   clk, rst (sync, active-low); bus (pc_gen_if.master): fetch handshake pc_valid/pc_o/fetch_ready,
//   redirect_*/trap_* next-PC sources, halt_req/resume_req debug control, halted,
//   misalign_o/misalign_pc fault report, issue_cnt accepted-fetch counter.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 32
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  localparam logic [XLEN-1:0] AMASK = XLEN'(IALIGN - 1);
  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, mpc_q, mpc_d, tpc_al;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d, acc, rd_ok, rd_bad;
  always_comb begin
    acc     = (state_q == RUN) && bus.fetch_ready;
    tpc_al  = bus.trap_pc & ~AMASK;
    rd_ok   = bus.redirect_valid && ((bus.redirect_pc & AMASK) == '0);
    rd_bad  = bus.redirect_valid && !rd_ok;
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    mpc_d   = mpc_q;
    // a handshake counts even when the same edge halts or redirects
    cnt_d   = cnt_q + CNT_W'(acc);
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.trap_valid) pc_d = tpc_al;
        else if (rd_ok) pc_d = bus.redirect_pc;
        else if (rd_bad) begin
          mis_d   = 1'b1;
          mpc_d   = bus.redirect_pc;
          state_d = FAULT;
        end
        else if (bus.halt_req) state_d = HALT;
        else if (bus.fetch_ready) pc_d = pc_q + XLEN'(4);
      end
      HALT: begin
        if (bus.trap_valid) begin
          pc_d    = tpc_al;
          state_d = RUN;
        end
        else if (rd_ok) pc_d = bus.redirect_pc;
        else if (bus.resume_req) state_d = RUN;
      end
      FAULT: begin
        if (bus.trap_valid) begin
          pc_d    = tpc_al;
          mis_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      mpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      mpc_q   <= mpc_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.pc_valid    = state_q == RUN;
  assign bus.halted      = state_q == HALT;
  assign bus.pc_o        = pc_q;
  assign bus.misalign_o  = mis_q;
  assign bus.misalign_pc = mpc_q;
  assign bus.issue_cnt   = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus with a due-cycle scoreboard checked by an independent monitor.
module tb_pc_gen;
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        h;
    logic        m;
    logic [31:0] mpc;
    logic [31:0] cnt;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;
  obs_t exp_q[$];
  int   due_q[$];
  int   id_q[$];
  pc_gen_if #(.XLEN(32), .CNT_W(32)) bus ();
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      obs_t a, e;
      int   id;
      a = '{bus.pc_valid, bus.pc_o, bus.halted, bus.misalign_o, bus.misalign_pc, bus.issue_cnt};
      e = exp_q.pop_front();
      id = id_q.pop_front();
      void'(due_q.pop_front());
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL step%0d got v=%b pc=%h h=%b m=%b mpc=%h cnt=%0d, want v=%b pc=%h h=%b m=%b mpc=%h cnt=%0d",
                 id, a.v, a.pc, a.h, a.m, a.mpc, a.cnt, e.v, e.pc, e.h, e.m, e.mpc, e.cnt);
      end
    end
  end
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic tv, input logic [31:0] tpc, input logic hr, input logic rr,
                      input logic v, input logic [31:0] pc, input logic h, input logic m,
                      input logic [31:0] mpc, input logic [31:0] cnt);
    rst                = r;
    bus.fetch_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.trap_valid     = tv;
    bus.trap_pc        = tpc;
    bus.halt_req       = hr;
    bus.resume_req     = rr;
    n_step++;
    exp_q.push_back('{v, pc, h, m, mpc, cnt});
    due_q.push_back(cyc + 1);
    id_q.push_back(n_step);
    @(posedge clk);
    #1;
  endtask
  initial begin
    //    rst rdy rv rpc           tv tpc          hr rr | v pc            h m mpc        cnt
    step(0, 0, 0, 32'h0,        0, 32'h0,       0, 0,  0, 32'h0,        0, 0, 32'h0,   0);
    step(0, 1, 1, 32'h200,      1, 32'h80,      1, 0,  0, 32'h0,        0, 0, 32'h0,   0);
    step(0, 0, 0, 32'h0,        0, 32'h0,       0, 0,  0, 32'h0,        0, 0, 32'h0,   0);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h0,        0, 0, 32'h0,   0);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h4,        0, 0, 32'h0,   1);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h8,        0, 0, 32'h0,   2);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'hC,        0, 0, 32'h0,   3);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h10,       0, 0, 32'h0,   4);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 32'h0,      0, 32'h0,       0, 0,  1, 32'h10,       0, 0, 32'h0,   4);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h14,       0, 0, 32'h0,   5);
    step(1, 1, 1, 32'h200,      1, 32'h81,      0, 0,  1, 32'h80,       0, 0, 32'h0,   6);
    step(1, 0, 1, 32'h200,      0, 32'h0,       0, 0,  1, 32'h200,      0, 0, 32'h0,   6);
    step(1, 1, 1, 32'h102,      0, 32'h0,       0, 0,  0, 32'h200,      0, 1, 32'h102, 7);
    step(1, 1, 1, 32'h300,      0, 32'h0,       0, 0,  0, 32'h200,      0, 1, 32'h102, 7);
    step(1, 1, 0, 32'h0,        0, 32'h0,       1, 1,  0, 32'h200,      0, 1, 32'h102, 7);
    step(1, 0, 0, 32'h0,        1, 32'h40,      0, 0,  1, 32'h40,       0, 0, 32'h102, 7);
    step(1, 0, 1, 32'h20,       0, 32'h0,       0, 0,  1, 32'h20,       0, 0, 32'h102, 7);
    step(1, 1, 0, 32'h0,        0, 32'h0,       1, 0,  0, 32'h20,       1, 0, 32'h102, 8);
    step(1, 1, 1, 32'h300,      0, 32'h0,       0, 0,  0, 32'h300,      1, 0, 32'h102, 8);
    step(1, 0, 0, 32'h0,        0, 32'h0,       1, 1,  1, 32'h300,      0, 0, 32'h102, 8);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h304,      0, 0, 32'h102, 9);
    step(1, 0, 0, 32'h0,        0, 32'h0,       1, 0,  0, 32'h304,      1, 0, 32'h102, 9);
    step(1, 0, 0, 32'h0,        1, 32'h103,     0, 0,  1, 32'h100,      0, 0, 32'h102, 9);
    step(1, 0, 1, 32'hFFFFFFFC, 0, 32'h0,       0, 0,  1, 32'hFFFFFFFC, 0, 0, 32'h102, 9);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h0,        0, 0, 32'h102, 10);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h4,        0, 0, 32'h102, 11);
    step(1, 0, 0, 32'h0,        0, 32'h0,       1, 0,  0, 32'h4,        1, 0, 32'h102, 11);
    step(0, 1, 1, 32'h300,      1, 32'h80,      0, 1,  0, 32'h0,        0, 0, 32'h0,   0);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h0,        0, 0, 32'h0,   0);
    step(1, 1, 0, 32'h0,        0, 32'h0,       0, 0,  1, 32'h4,        0, 0, 32'h0,   1);
    for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge clk);
    if (due_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never checked, want 0", due_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32 fetch front end. It holds the current fetch address and presents it to instruction fetch with a valid/ready handshake. The next PC is chosen from trap entry, branch/jump redirect, halt/hold, or sequential +4. It detects misaligned redirect targets, supports a debug halt/resume mode, and counts accepted fetch addresses.

## Interface
Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (XLEN bits, aligned).
- IALIGN, 4, required instruction alignment in bytes (4, or 2 when compressed support is on).
- CNT_W, 32, width of the issued-address counter.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- fetch_ready  in  1  fetch accepts pc_o this cycle.
- pc_valid  out  1  pc_o is a valid fetch request.
- pc_o  out  XLEN  current fetch address.
- redirect_valid  in  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- trap_valid  in  1  trap entry; load trap_pc.
- trap_pc  in  XLEN  trap vector; low log2(IALIGN) bits forced to 0 on load.
- halt_req  in  1  debug halt request.
- resume_req  in  1  debug resume request.
- halted  out  1  block is in HALT.
- misalign_o  out  1  sticky misaligned-target flag, high in FAULT.
- misalign_pc  out  XLEN  offending redirect target.
- issue_cnt  out  CNT_W  number of accepted handshakes (pc_valid & fetch_ready), wraps.

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset (rst=0 at an edge): state=BOOT, pc_o=RESET_VECTOR, pc_valid=0, halted=0, misalign_o=0, misalign_pc=0, issue_cnt=0. Reset wins over every other input.
- BOOT: pc_valid=0. Goes to RUN on the next edge; pc_o keeps RESET_VECTOR.
- RUN: pc_valid=1. Next-state priority at each edge:
  - trap_valid: pc_o<=aligned trap_pc, stay RUN.
  - redirect_valid with an aligned target: pc_o<=redirect_pc, stay RUN. This happens regardless of fetch_ready; the pending address is discarded.
  - redirect_valid with a misaligned target (redirect_pc mod IALIGN != 0): pc_o holds, misalign_o<=1, misalign_pc<=redirect_pc, go FAULT.
  - halt_req: pc_o holds, go HALT. A handshake completing in the same cycle still counts but does not advance pc_o.
  - fetch_ready: pc_o<=pc_o+4 modulo 2^XLEN.
  - otherwise: hold (backpressure).
- HALT: pc_valid=0, halted=1.
  - trap_valid loads trap_pc and goes RUN.
  - Else redirect_valid (aligned) loads pc_o and stays HALT.
  - Else resume_req goes RUN with pc_o unchanged.
  - halt_req and resume_req together: resume wins.
- FAULT: pc_valid=0. Only trap_valid leaves FAULT: it loads trap_pc, clears misalign_o, and goes RUN. Redirect, halt and resume are ignored.
- issue_cnt increments on every edge where pc_valid & fetch_ready, in any state where pc_valid=1. It wraps at 2^CNT_W.
- Increment is always +4, including when IALIGN=2. Compressed realignment is fetch's job.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Redirect or trap asserted in cycle N: pc_o=target and pc_valid=1 in cycle N+1. This is a one-cycle redirect latency.
- After rst released at edge E: BOOT in cycle E+1, first valid request (RESET_VECTOR) in cycle E+2.
- Handshake: pc_o is stable while pc_valid=1 and fetch_ready=0, unless a redirect or trap arrives.
- Sequential wrap: pc_o=2^XLEN-4 with an accept gives 0 next cycle.
- Reset asserted mid-RUN, HALT or FAULT returns to BOOT on that edge and ignores all other inputs.

## Test plan
- Reset/boot: hold rst=0 for 3 cycles, release, fetch_ready=1 -> pc_valid 0,0 then pc_o 0x0,0x4,0x8; issue_cnt increments 1,2,3.
- Backpressure: fetch_ready=0 for 4 cycles at pc_o=0x10 -> pc_o stays 0x10 and issue_cnt is frozen; ready=1 -> 0x14.
- Redirect vs trap: redirect_valid (0x200) and trap_valid (0x81) in the same cycle -> next pc_o=0x80. Redirect alone to 0x200 with fetch_ready=0 -> next pc_o=0x200.
- Misalign: IALIGN=4, redirect_pc=0x102 -> FAULT, misalign_o=1, misalign_pc=0x102, pc_valid=0. Redirects are then ignored. trap_pc=0x40 -> RUN at 0x40 with misalign_o=0.
- Halt/resume: halt_req at pc_o=0x20 -> halted=1, pc_valid=0. Redirect 0x300 while halted -> pc_o=0x300 with halted still 1. resume_req -> pc_valid=1 at 0x300.
- Wrap/reset mid-op: pc_o=0xFFFF_FFFC accepted -> 0x0000_0000. rst=0 asserted while in HALT -> BOOT, pc_o=RESET_VECTOR, halted=0, issue_cnt=0.
